// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state encoding and the two-word Ldl
// opcode detector. Decode uses the same detector, so both stages agree on
// which words carry a trailing literal.
package cpu_pkg;

    // Fetch FSM states: SETTLE waits out memory latency after a PC load,
    // OPCODE captures the first word, LITW/LITERAL fetch an Ldl literal,
    // HOLD presents the packet to decode.
    typedef enum logic [2:0] {
        ST_SETTLE  = 3'd0,
        ST_OPCODE  = 3'd1,
        ST_LITW    = 3'd2,
        ST_LITERAL = 3'd3,
        ST_HOLD    = 3'd4
    } fetch_state_t;

    // Upper 12 bits of an Ldl opcode; the low nibble selects the register.
    localparam logic [11:0] LDL_MATCH = 12'hFF1;

    // True when the word is an Ldl opcode, i.e. a literal word follows it.
    function automatic logic is_ldl(input logic [15:0] word);
        return (word[15:4] == LDL_MATCH);
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Drives the memory address from the PC, waits out
// the one-cycle registered read, folds Ldl opcode + literal into a single
// packet and offers it to decode on a valid/ready handshake. A redirect from
// execute discards whatever is being assembled or held and refetches from the
// new PC.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0010
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] i_addr,
    input  logic [15:0] i_bus,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [15:0] out_lit,
    output logic        out_has_lit,
    output logic [15:0] out_pc
);

    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  instr_q, instr_d;
    logic [15:0]  lit_q, lit_d;
    logic         has_lit_q, has_lit_d;
    logic [15:0]  out_pc_q, out_pc_d;

    // State and datapath registers; reset returns to a clean SETTLE at RESET_PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_SETTLE;
            pc_q      <= RESET_PC;
            instr_q   <= 16'h0000;
            lit_q     <= 16'h0000;
            has_lit_q <= 1'b0;
            out_pc_q  <= 16'h0000;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            lit_q     <= lit_d;
            has_lit_q <= has_lit_d;
            out_pc_q  <= out_pc_d;
        end
    end

    // Next-state: redirect wins over every other transition.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (redirect) begin
            state_d = ST_SETTLE;
        end else begin
            case (state_q)
                ST_SETTLE:  state_d = ST_OPCODE;
                ST_OPCODE:  state_d = is_ldl(i_bus) ? ST_LITW : ST_HOLD;
                ST_LITW:    state_d = ST_LITERAL;
                ST_LITERAL: state_d = ST_HOLD;
                ST_HOLD:    state_d = out_ready ? ST_OPCODE : ST_HOLD;
                default:    state_d = ST_SETTLE;
            endcase
        end
    end

    // Datapath next values: PC advance and packet assembly.
    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        lit_d     = lit_q;
        has_lit_d = has_lit_q;
        out_pc_d  = out_pc_q;
        if (redirect) begin
            // Packet registers are left as-is; out_valid drops, so their
            // contents are never seen by decode.
            pc_d = redirect_pc;
        end else begin
            case (state_q)
                ST_OPCODE: begin
                    instr_d   = i_bus;
                    out_pc_d  = pc_q;
                    pc_d      = pc_q + 16'd1;
                    lit_d     = 16'h0000;
                    has_lit_d = 1'b0;
                end
                ST_LITERAL: begin
                    lit_d     = i_bus;
                    has_lit_d = 1'b1;
                    pc_d      = pc_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: packet is valid only while holding; all fields come from registers.
    always_comb begin
        out_valid = (state_q == ST_HOLD);
    end

    assign i_addr      = pc_q;
    assign out_instr   = instr_q;
    assign out_lit     = lit_q;
    assign out_has_lit = has_lit_q;
    assign out_pc      = out_pc_q;

endmodule
